// File: rtl/reg_file_responder.sv
// Valid/ready register-file responder. Accepted requests are served immediately and their responses queue in order.
// Define RESP_FORMAL_PROPS_EN to add the embedded immediate assume/assert/cover properties.
module reg_file_responder #(
   parameter int AW    = 3,
   parameter int DW    = 8,
   parameter int DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic          rsp_we,
   output logic [DW-1:0] rsp_rdata
);

   localparam int NREG = 2 ** AW;
   localparam int CW   = $clog2(DEPTH + 1);
   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DW-1:0] regs_reg      [NREG];
   logic          fifo_we_reg   [DEPTH];
   logic [DW-1:0] fifo_data_reg [DEPTH];
   logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
   logic [CW-1:0] count_reg, count_next;

   logic          push;
   logic          pop;
   logic          push_we;
   logic [DW-1:0] push_data;

   // req_ready depends only on the registered count, never on rsp_ready
   assign req_ready = (count_reg < CW'(DEPTH));
   assign rsp_valid = (count_reg != '0);
   assign push      = req_valid && req_ready;
   assign pop       = rsp_valid && rsp_ready;
   assign push_we   = req_we;
   assign push_data = req_we ? '0 : regs_reg[req_addr];
   assign rsp_we    = rsp_valid ? fifo_we_reg[rd_ptr_reg] : 1'b0;
   assign rsp_rdata = rsp_valid ? fifo_data_reg[rd_ptr_reg] : '0;

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (push) begin
         wr_ptr_next = (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
      end
      if (pop) begin
         rd_ptr_next = (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);
      end
      if (push && !pop) begin
         count_next = count_reg + CW'(1);
      end else if (!push && pop) begin
         count_next = count_reg - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_regs
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               regs_reg[gi] <= '0;
            end else if (push && req_we && (req_addr == AW'(gi))) begin
               regs_reg[gi] <= req_wdata;
            end
         end
      end

      for (gi = 0; gi < DEPTH; gi++) begin : g_fifo
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               fifo_we_reg[gi]   <= 1'b0;
               fifo_data_reg[gi] <= '0;
            end else if (push && (wr_ptr_reg == PW'(gi))) begin
               fifo_we_reg[gi]   <= push_we;
               fifo_data_reg[gi] <= push_data;
            end
         end
      end
   endgenerate

`ifdef RESP_FORMAL_PROPS_EN
   // Cleared by reset so $past never reaches across a reset boundary
   logic past_valid_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         past_valid_reg <= 1'b0;
      end else begin
         past_valid_reg <= 1'b1;
      end
   end

   always @(posedge clk) begin
      if (past_valid_reg && rst_n) begin
         if ($past(req_valid && !req_ready)) begin
            req_stable: assume (req_valid && (req_we == $past(req_we)) &&
                                (req_addr == $past(req_addr)) &&
                                (req_wdata == $past(req_wdata)));
         end
         if ($past(rsp_valid && !rsp_ready)) begin
            rsp_stable: assert (rsp_valid && (rsp_we == $past(rsp_we)) &&
                                (rsp_rdata == $past(rsp_rdata)));
         end
         cnt_bound: assert (count_reg <= CW'(DEPTH));
         rdy_full:  assert (req_ready == (count_reg != CW'(DEPTH)));
         if ($past(req_valid && req_ready && req_we)) begin
            wr_visible: assert (regs_reg[$past(req_addr)] == $past(req_wdata));
         end
         hit_full:     cover (count_reg == CW'(DEPTH));
         back_to_back: cover ($past(rsp_valid && rsp_ready) && rsp_valid);
      end
   end
`endif

endmodule

// File: tb/tb_reg_file_responder.sv
// Directed self-checking bench for reg_file_responder (AW=3, DW=8, DEPTH=2).
module tb_reg_file_responder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid;
   logic       req_ready;
   logic       req_we;
   logic [2:0] req_addr;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic       rsp_ready;
   logic       rsp_we;
   logic [7:0] rsp_rdata;

   int tests  = 0;
   int failed = 0;

   reg_file_responder #(.AW(3), .DW(8), .DEPTH(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_we    (rsp_we),
      .rsp_rdata (rsp_rdata)
   );

   always #5 clk = ~clk;

   // One line per request accept and per response pop
   always @(posedge clk) begin
      if (rst_n && req_valid && req_ready)
         $display("[TB] %0t req accept we=%0b addr=%0d wdata=%h", $time, req_we, req_addr, req_wdata);
      if (rst_n && rsp_valid && rsp_ready)
         $display("[TB] %0t rsp pop    we=%0b rdata=%h", $time, rsp_we, rsp_rdata);
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic v, input logic we, input logic [2:0] a, input logic [7:0] d);
      req_valid = v;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rsp_ready = 1'b0;
      drive_req(1'b0, 1'b0, 3'd0, 8'h00);
      step();
      step();
      rst_n = 1'b1;
      tests++; if (req_ready !== 1'b1) begin failed++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
      tests++; if (rsp_valid !== 1'b0) begin failed++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
      tests++; if (rsp_rdata !== 8'h00) begin failed++; $display("FAIL rst_rsp_rdata: got %h want 00", rsp_rdata); end
      tests++; if (rsp_we !== 1'b0) begin failed++; $display("FAIL rst_rsp_we: got %b want 0", rsp_we); end
      rsp_ready = 1'b1;
      drive_req(1'b1, 1'b0, 3'd5, 8'h00);
      step();
      drive_req(1'b0, 1'b0, 3'd0, 8'h00);
      tests++; if (rsp_valid !== 1'b1) begin failed++; $display("FAIL rst_rd5_valid: got %b want 1", rsp_valid); end
      tests++; if (rsp_we !== 1'b0) begin failed++; $display("FAIL rst_rd5_we: got %b want 0", rsp_we); end
      tests++; if (rsp_rdata !== 8'h00) begin failed++; $display("FAIL rst_rd5_rdata: got %h want 00", rsp_rdata); end
      step();
      tests++; if (rsp_valid !== 1'b0) begin failed++; $display("FAIL rst_rd5_drain: got %b want 0", rsp_valid); end
   endtask

   task automatic test_write_read();
      rsp_ready = 1'b1;
      drive_req(1'b1, 1'b1, 3'd3, 8'hA5);
      step();
      drive_req(1'b1, 1'b0, 3'd3, 8'h00);
      tests++; if (rsp_valid !== 1'b1 || rsp_we !== 1'b1 || rsp_rdata !== 8'h00) begin
         failed++; $display("FAIL wr_rsp: got v=%b we=%b d=%h want v=1 we=1 d=00", rsp_valid, rsp_we, rsp_rdata);
      end
      step();
      drive_req(1'b0, 1'b0, 3'd0, 8'h00);
      tests++; if (rsp_valid !== 1'b1 || rsp_we !== 1'b0 || rsp_rdata !== 8'hA5) begin
         failed++; $display("FAIL rd_rsp: got v=%b we=%b d=%h want v=1 we=0 d=a5", rsp_valid, rsp_we, rsp_rdata);
      end
      step();
      tests++; if (rsp_valid !== 1'b0) begin failed++; $display("FAIL wr_rd_drain: got %b want 0", rsp_valid); end
   endtask

   task automatic test_backpressure();
      rsp_ready = 1'b1;
      drive_req(1'b1, 1'b1, 3'd6, 8'h66);
      step();
      drive_req(1'b0, 1'b0, 3'd0, 8'h00);
      step();
      rsp_ready = 1'b0;
      drive_req(1'b1, 1'b0, 3'd3, 8'h00);
      step();
      tests++; if (req_ready !== 1'b1) begin failed++; $display("FAIL bp_ready_one: got %b want 1", req_ready); end
      tests++; if (rsp_rdata !== 8'hA5) begin failed++; $display("FAIL bp_head_one: got %h want a5", rsp_rdata); end
      drive_req(1'b1, 1'b0, 3'd6, 8'h00);
      step();
      drive_req(1'b0, 1'b0, 3'd0, 8'h00);
      tests++; if (req_ready !== 1'b0) begin failed++; $display("FAIL bp_ready_full: got %b want 0", req_ready); end
      step();
      tests++; if (rsp_valid !== 1'b1 || rsp_we !== 1'b0 || rsp_rdata !== 8'hA5) begin
         failed++; $display("FAIL bp_hold: got v=%b we=%b d=%h want v=1 we=0 d=a5", rsp_valid, rsp_we, rsp_rdata);
      end
      tests++; if (req_ready !== 1'b0) begin failed++; $display("FAIL bp_ready_hold: got %b want 0", req_ready); end
      rsp_ready = 1'b1;
      step();
      tests++; if (rsp_rdata !== 8'h66) begin failed++; $display("FAIL bp_drain2: got %h want 66", rsp_rdata); end
      tests++; if (req_ready !== 1'b1) begin failed++; $display("FAIL bp_ready_back: got %b want 1", req_ready); end
      step();
      tests++; if (rsp_valid !== 1'b0) begin failed++; $display("FAIL bp_empty: got %b want 0", rsp_valid); end
   endtask

   task automatic test_full_pop();
      rsp_ready = 1'b0;
      drive_req(1'b1, 1'b0, 3'd3, 8'h00);
      step();
      drive_req(1'b1, 1'b0, 3'd6, 8'h00);
      step();
      drive_req(1'b1, 1'b1, 3'd2, 8'h22);
      rsp_ready = 1'b1;
      tests++; if (req_ready !== 1'b0) begin failed++; $display("FAIL fp_ready_full: got %b want 0", req_ready); end
      step();
      tests++; if (rsp_valid !== 1'b1 || rsp_we !== 1'b0 || rsp_rdata !== 8'h66) begin
         failed++; $display("FAIL fp_second: got v=%b we=%b d=%h want v=1 we=0 d=66", rsp_valid, rsp_we, rsp_rdata);
      end
      tests++; if (req_ready !== 1'b1) begin failed++; $display("FAIL fp_ready_after_pop: got %b want 1", req_ready); end
      step();
      drive_req(1'b0, 1'b0, 3'd0, 8'h00);
      tests++; if (rsp_valid !== 1'b1 || rsp_we !== 1'b1 || rsp_rdata !== 8'h00) begin
         failed++; $display("FAIL fp_write_rsp: got v=%b we=%b d=%h want v=1 we=1 d=00", rsp_valid, rsp_we, rsp_rdata);
      end
      step();
      tests++; if (rsp_valid !== 1'b0) begin failed++; $display("FAIL fp_no_dup: got %b want 0", rsp_valid); end
      drive_req(1'b1, 1'b0, 3'd2, 8'h00);
      step();
      drive_req(1'b0, 1'b0, 3'd0, 8'h00);
      tests++; if (rsp_rdata !== 8'h22) begin failed++; $display("FAIL fp_readback: got %h want 22", rsp_rdata); end
      step();
   endtask

   task automatic test_reset_mid();
      rsp_ready = 1'b1;
      drive_req(1'b1, 1'b1, 3'd1, 8'h3C);
      step();
      drive_req(1'b0, 1'b0, 3'd0, 8'h00);
      step();
      rsp_ready = 1'b0;
      drive_req(1'b1, 1'b0, 3'd1, 8'h00);
      step();
      step();
      drive_req(1'b0, 1'b0, 3'd0, 8'h00);
      tests++; if (rsp_rdata !== 8'h3C || req_ready !== 1'b0) begin
         failed++; $display("FAIL rm_queued: got d=%h rdy=%b want d=3c rdy=0", rsp_rdata, req_ready);
      end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      tests++; if (rsp_valid !== 1'b0) begin failed++; $display("FAIL rm_valid: got %b want 0", rsp_valid); end
      tests++; if (req_ready !== 1'b1) begin failed++; $display("FAIL rm_ready: got %b want 1", req_ready); end
      rsp_ready = 1'b1;
      drive_req(1'b1, 1'b0, 3'd1, 8'h00);
      step();
      drive_req(1'b0, 1'b0, 3'd0, 8'h00);
      tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h00) begin
         failed++; $display("FAIL rm_read1: got v=%b d=%h want v=1 d=00", rsp_valid, rsp_rdata);
      end
      step();
      tests++; if (rsp_valid !== 1'b0) begin failed++; $display("FAIL rm_drain: got %b want 0", rsp_valid); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_backpressure();
      test_full_pop();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
